// File: rtl/verificador_senha.sv
// Code-entry checker for the lock controller: compares entered digits against a code,
// reports total/partial success or failure, and enforces a timed lockout after repeated failures.
//
// state           | meaning
// INICIAL         | idle, waiting for the first digit
// ENTRADA         | digits being entered
// SUCESSO_TOTAL   | all digits correct
// SUCESSO_PARCIAL | code complete with 1..MAX_ERR wrong digits
// FALHA           | too many wrong digits; waiting for limpa
// BLOQUEIO        | lockout timer running; all input ignored
module verificador_senha #(
  parameter int DIGIT_W     = 4,
  parameter int CODE_LEN    = 6,
  parameter int MAX_ERR     = 1,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        insere,
  input  logic [DIGIT_W-1:0]          numero,
  input  logic [CODE_LEN*DIGIT_W-1:0] codigo,
  input  logic                        limpa,
  output logic [2:0]                  estado,
  output logic                        led,
  output logic                        led_parcial,
  output logic [3:0]                  acertos,
  output logic [3:0]                  erros,
  output logic [3:0]                  tentativas,
  output logic [6:0]                  display
);

  typedef enum logic [2:0] {
    INICIAL         = 3'd0,
    ENTRADA         = 3'd1,
    SUCESSO_TOTAL   = 3'd2,
    SUCESSO_PARCIAL = 3'd3,
    FALHA           = 3'd4,
    BLOQUEIO        = 3'd5
  } state_t;

  localparam int PAD_LEN = 16;
  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [3:0]     LAST_IDX    = 4'(CODE_LEN - 1);
  localparam logic [3:0]     MAX_ERR_V   = 4'(MAX_ERR);
  localparam logic [3:0]     MAX_TRIES_V = 4'(MAX_TRIES);
  localparam logic [LCW-1:0] LOCK_LOAD   = LCW'(LOCK_CYCLES - 1);

  state_t                        state;
  logic                          insere_q;
  logic [CODE_LEN*DIGIT_W-1:0]   codigo_q;
  logic [3:0]                    idx;
  logic [LCW-1:0]                lock_cnt;

  logic                          entry;
  logic [PAD_LEN*DIGIT_W-1:0]    code_pad;
  logic [DIGIT_W-1:0]            expected;
  logic                          hit;
  logic                          last;
  logic [3:0]                    acertos_nx;
  logic [3:0]                    erros_nx;
  logic [3:0]                    tent_nx;
  logic [3:0]                    total;

  assign entry = insere & ~insere_q;

  // The first digit is checked against the live code, since the latch happens on that same edge.
  assign code_pad   = {{((PAD_LEN - CODE_LEN) * DIGIT_W){1'b0}},
                       (state == INICIAL) ? codigo : codigo_q};
  assign expected   = code_pad[idx*DIGIT_W +: DIGIT_W];
  assign hit        = (numero == expected);
  assign last       = (idx == LAST_IDX);
  assign acertos_nx = acertos + {3'b000, hit};
  assign erros_nx   = erros + {3'b000, ~hit};
  assign tent_nx    = tentativas + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INICIAL;
      insere_q   <= 1'b1;
      codigo_q   <= '0;
      idx        <= '0;
      lock_cnt   <= '0;
      acertos    <= '0;
      erros      <= '0;
      tentativas <= '0;
    end else begin
      insere_q <= insere;
      case (state)
        INICIAL, ENTRADA: begin
          if (limpa) begin
            state   <= INICIAL;
            acertos <= '0;
            erros   <= '0;
            idx     <= '0;
          end else if (entry) begin
            if (state == INICIAL) codigo_q <= codigo;
            acertos <= acertos_nx;
            erros   <= erros_nx;
            if (erros_nx > MAX_ERR_V) begin
              tentativas <= tent_nx;
              if (tent_nx == MAX_TRIES_V) begin
                state    <= BLOQUEIO;
                lock_cnt <= LOCK_LOAD;
              end else begin
                state <= FALHA;
              end
            end else if (last) begin
              state      <= (erros_nx == 4'd0) ? SUCESSO_TOTAL : SUCESSO_PARCIAL;
              tentativas <= '0;
            end else begin
              idx   <= idx + 4'd1;
              state <= ENTRADA;
            end
          end
        end
        SUCESSO_TOTAL, SUCESSO_PARCIAL, FALHA: begin
          if (limpa) begin
            state   <= INICIAL;
            acertos <= '0;
            erros   <= '0;
            idx     <= '0;
          end
        end
        BLOQUEIO: begin
          if (lock_cnt == '0) begin
            state      <= INICIAL;
            acertos    <= '0;
            erros      <= '0;
            idx        <= '0;
            tentativas <= '0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: begin
          state   <= INICIAL;
          acertos <= '0;
          erros   <= '0;
          idx     <= '0;
        end
      endcase
    end
  end

  assign estado      = state;
  assign led         = (state == SUCESSO_TOTAL) || (state == SUCESSO_PARCIAL);
  assign led_parcial = (state == SUCESSO_PARCIAL);
  assign total       = acertos + erros;

  always_comb begin
    display = 7'b0111111;
    case (state)
      INICIAL, ENTRADA: begin
        case (total)
          4'h0: display = 7'b0111111;
          4'h1: display = 7'b0000110;
          4'h2: display = 7'b1011011;
          4'h3: display = 7'b1001111;
          4'h4: display = 7'b1100110;
          4'h5: display = 7'b1101101;
          4'h6: display = 7'b1111101;
          4'h7: display = 7'b0000111;
          4'h8: display = 7'b1111111;
          4'h9: display = 7'b1101111;
          4'hA: display = 7'b1110111;
          4'hB: display = 7'b1111100;
          4'hC: display = 7'b0111001;
          4'hD: display = 7'b1011110;
          4'hE: display = 7'b1111001;
          default: display = 7'b1110001;
        endcase
      end
      SUCESSO_TOTAL:   display = 7'b1101101;
      SUCESSO_PARCIAL: display = 7'b1110011;
      FALHA:           display = 7'b1110001;
      BLOQUEIO:        display = 7'b0111000;
      default:         display = 7'b0111111;
    endcase
  end

endmodule
